// File: rtl/ctrl_multiciclo.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback over one shared
// ULA and one memory port, tolerates memory wait states, counts retirements and traps illegal code.
module ctrl_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [6:0]       iOpcode,
  input  logic [2:0]       iFunct3,
  input  logic             iFunct7b5,
  input  logic             iZero,
  input  logic             iMemReady,
  output logic             oPCWrite,
  output logic             oIRWrite,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oRegWrite,
  output logic [1:0]       oMem2Reg,
  output logic [1:0]       oOrigAULA,
  output logic [1:0]       oOrigBULA,
  output logic [4:0]       oULAControl,
  output logic [1:0]       oOrigPC,
  output logic [3:0]       oEstado,
  output logic [CNT_W-1:0] oNInstr,
  output logic             oErro
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_FOUR  = 2'b01;
  localparam logic [1:0] B_IMM   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JAL    = 4'd9,
    S_JALR   = 4'd10,
    S_LUI    = 4'd11,
    S_WB_ALU = 4'd12,
    S_ERRO   = 4'd15
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                retire;
  logic                mem_tmo;
  logic                in_wait;

  // Last permitted stall cycle: the next !iMemReady would exceed the budget.
  assign mem_tmo = (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));
  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign oEstado = 4'(state);

  // Next state and Moore strobes (FETCH/MEM_* additionally gated by iMemReady).
  always_comb begin
    state_nx    = state;
    retire      = 1'b0;
    oPCWrite    = 1'b0;
    oIRWrite    = 1'b0;
    oIorD       = 1'b0;
    oMemRead    = 1'b0;
    oMemWrite   = 1'b0;
    oRegWrite   = 1'b0;
    oMem2Reg    = WB_ALUOUT;
    oOrigAULA   = A_PC;
    oOrigBULA   = B_RS2;
    oULAControl = ALU_ADD;
    oOrigPC     = PC_ALU;

    case (state)
      S_FETCH: begin
        oIorD     = 1'b0;
        oMemRead  = 1'b1;
        oOrigAULA = A_PC;
        oOrigBULA = B_FOUR;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          oOrigPC  = PC_ALU;
          state_nx = S_DECODE;
        end else if (mem_tmo) begin
          state_nx = S_ERRO;
        end
      end

      S_DECODE: begin
        oOrigAULA = A_OLDPC;
        oOrigBULA = B_IMM;
        case (iOpcode)
          OP_R:               state_nx = S_EXEC_R;
          OP_I, OP_AUIPC:     state_nx = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nx = S_ADDR;
          OP_BRANCH:          state_nx = S_BRANCH;
          OP_JAL:             state_nx = S_JAL;
          OP_JALR:            state_nx = S_JALR;
          OP_LUI:             state_nx = S_LUI;
          default:            state_nx = S_ERRO;
        endcase
      end

      S_EXEC_R: begin
        oOrigAULA   = A_RS1;
        oOrigBULA   = B_RS2;
        oULAControl = {1'b0, iFunct7b5, iFunct3};
        state_nx    = S_WB_ALU;
      end

      // AUIPC shares this state; the IR opcode selects oldPC + imm.
      S_EXEC_I: begin
        oOrigBULA = B_IMM;
        if (iOpcode == OP_AUIPC) begin
          oOrigAULA   = A_OLDPC;
          oULAControl = ALU_ADD;
        end else begin
          oOrigAULA   = A_RS1;
          oULAControl = {1'b0, (iFunct3 == 3'b101) ? iFunct7b5 : 1'b0, iFunct3};
        end
        state_nx = S_WB_ALU;
      end

      S_WB_ALU: begin
        oRegWrite = 1'b1;
        oMem2Reg  = WB_ALUOUT;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end

      S_ADDR: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        state_nx  = (iOpcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        oIorD    = 1'b1;
        oMemRead = 1'b1;
        if (iMemReady)    state_nx = S_MEM_WB;
        else if (mem_tmo) state_nx = S_ERRO;
      end

      S_MEM_WB: begin
        oRegWrite = 1'b1;
        oMem2Reg  = WB_MDR;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end

      S_MEM_WR: begin
        oIorD     = 1'b1;
        oMemWrite = 1'b1;
        if (iMemReady) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else if (mem_tmo) begin
          state_nx = S_ERRO;
        end
      end

      // Only beq/bne are supported; any other funct3 traps without touching PC.
      S_BRANCH: begin
        oOrigAULA   = A_RS1;
        oOrigBULA   = B_RS2;
        oULAControl = ALU_SUB;
        if (iFunct3 == 3'b000 || iFunct3 == 3'b001) begin
          if ((iFunct3 == 3'b000) ? iZero : !iZero) begin
            oPCWrite = 1'b1;
            oOrigPC  = PC_ALUOUT;
          end
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_ERRO;
        end
      end

      S_JAL: begin
        oRegWrite = 1'b1;
        oMem2Reg  = WB_PC4;
        oPCWrite  = 1'b1;
        oOrigPC   = PC_ALUOUT;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end

      S_JALR: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        oRegWrite = 1'b1;
        oMem2Reg  = WB_PC4;
        oPCWrite  = 1'b1;
        oOrigPC   = PC_ALU;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end

      S_LUI: begin
        oOrigAULA = A_ZERO;
        oOrigBULA = B_IMM;
        state_nx  = S_WB_ALU;
      end

      S_ERRO: state_nx = S_ERRO;

      default: state_nx = S_ERRO;
    endcase
  end

  // State, retirement counter, sticky error and memory wait counter.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_FETCH;
      oNInstr  <= '0;
      oErro    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (retire) oNInstr <= oNInstr + CNT_W'(1);
      if (state_nx == S_ERRO) oErro <= 1'b1;
      if (state_nx != state) wait_cnt <= '0;
      else if (in_wait && !iMemReady) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule
